// File: rtl/ln_pkg.sv
// Shared LayerNorm definitions: Q-format constants, datapath widths,
// the stage-3 statistics record, and saturation helpers.
package ln_pkg;

    localparam int unsigned INV_FRAC   = 12;
    localparam int unsigned GAMMA_FRAC = 14;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned MEAN_W     = 32;
    localparam int unsigned INV_W      = 16;
    localparam int unsigned BANK_W     = 2;
    localparam int unsigned NORM_W     = 18;
    localparam int unsigned ACC_W      = 36;

    localparam logic signed [ACC_W-1:0] INV_RND   = ACC_W'(2 ** (INV_FRAC - 1));
    localparam logic signed [ACC_W-1:0] GAMMA_RND = ACC_W'(2 ** (GAMMA_FRAC - 1));
    localparam logic signed [ACC_W-1:0] NORM_MAX  = 36'sd131071;
    localparam logic signed [ACC_W-1:0] NORM_MIN  = -36'sd131072;
    localparam logic signed [ACC_W-1:0] DATA_MAX  = 36'sd32767;
    localparam logic signed [ACC_W-1:0] DATA_MIN  = -36'sd32768;

    typedef struct packed {
        logic signed [MEAN_W-1:0] mean;
        logic [INV_W-1:0]         inv_sqrt;
        logic [BANK_W-1:0]        bank;
    } ln_stat_t;

    localparam int unsigned STAT_W = $bits(ln_stat_t);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    function automatic logic signed [NORM_W-1:0] sat18(input logic signed [ACC_W-1:0] v);
        if (v > NORM_MAX) return {1'b0, {(NORM_W-1){1'b1}}};
        if (v < NORM_MIN) return {1'b1, {(NORM_W-1){1'b0}}};
        return v[NORM_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > DATA_MAX) return {1'b0, {(DATA_W-1){1'b1}}};
        if (v < DATA_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
        return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/ln_stat_fifo.sv
// Small FIFO of per-vector statistics; a push into a full FIFO is dropped
// unless a pop frees the slot in the same cycle, and sets a sticky overflow.
module ln_stat_fifo
    import ln_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [STAT_W-1:0] i_data,
    input  logic              i_pop,
    output logic [STAT_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [STAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign o_empty = (count == '0);
    assign o_full  = (count == CNT_W'(DEPTH));
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);
    assign o_head  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (i_push && !do_push) o_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/ln_stage4_normalize.sv
// LayerNorm final stage: reads each vector from the bank buffer and emits
// sat16(((x-mean)*inv_sqrt)*gamma + beta) through a 4-stage stallable pipe.
module ln_stage4_normalize
    import ln_pkg::*;
#(
    parameter int unsigned VEC_LEN    = 768,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned STAT_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [31:0]       i_mean,
    input  logic [15:0]       i_inv_sqrt,
    input  logic [1:0]        i_bank_id,
    output logic              o_rd_en,
    output logic [1:0]        o_rd_bank,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [15:0]       i_rd_data,
    input  logic [15:0]       i_gamma,
    input  logic [15:0]       i_beta,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [15:0]       o_data,
    output logic              o_last,
    output logic              o_bank_free,
    output logic [1:0]        o_bank_free_id,
    output logic              o_overflow,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);

    state_t            state;
    state_t            state_next;
    ln_stat_t          act;
    ln_stat_t          head;
    logic [STAT_W-1:0] head_bits;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W-1:0] cnt;
    logic              stall;
    logic              rd_en;
    logic              load;
    logic              cnt_inc;
    logic              last_rd;

    ln_stat_fifo #(.DEPTH(STAT_DEPTH)) u_stat_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_push     (i_valid),
        .i_data     ({i_mean, i_inv_sqrt, i_bank_id}),
        .i_pop      (load),
        .o_head     (head_bits),
        .o_empty    (fifo_empty),
        .o_full     (fifo_full),
        .o_overflow (o_overflow)
    );

    assign head  = ln_stat_t'(head_bits);
    assign stall = o_valid & ~i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Loading the next stat on the last address keeps vectors back-to-back.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        load       = 1'b0;
        cnt_inc    = 1'b0;
        last_rd    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    rd_en = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        last_rd = 1'b1;
                        if (!fifo_empty) load = 1'b1;
                        else             state_next = S_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
            act <= '0;
        end else if (load) begin
            cnt <= '0;
            act <= head;
        end else if (cnt_inc) begin
            cnt <= cnt + 1'b1;
        end else if (last_rd) begin
            cnt <= '0;
        end
    end

    assign o_rd_en        = rd_en;
    assign o_rd_addr      = cnt;
    assign o_rd_bank      = act.bank;
    assign o_bank_free    = last_rd;
    assign o_bank_free_id = act.bank;

    logic                     v0, v1, v2;
    logic                     last0, last1, last2;
    logic signed [MEAN_W-1:0] mean0;
    logic [INV_W-1:0]         inv0, inv1;
    logic signed [NORM_W-1:0] d1, n2;
    logic signed [DATA_W-1:0] gamma1, gamma2, beta1, beta2;
    logic signed [ACC_W-1:0]  diff_w, prod_n, prod_a, a_w;
    logic signed [NORM_W-1:0] d_w, n_w;
    logic signed [DATA_W-1:0] y_w;

    always_comb begin
        diff_w = 36'($signed(i_rd_data)) - 36'(mean0);
        d_w    = sat18(diff_w);
        prod_n = 36'(d1) * 36'($signed({1'b0, inv1})) + INV_RND;
        n_w    = sat18(prod_n >>> INV_FRAC);
        prod_a = 36'(n2) * 36'(gamma2) + GAMMA_RND;
        a_w    = (prod_a >>> GAMMA_FRAC) + 36'(beta2);
        y_w    = sat16(a_w);
    end

    // Stage 0 has no data register: the buffer holds i_rd_data across a stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v0      <= 1'b0;  v1     <= 1'b0;  v2     <= 1'b0;
            last0   <= 1'b0;  last1  <= 1'b0;  last2  <= 1'b0;
            mean0   <= '0;    inv0   <= '0;    inv1   <= '0;
            d1      <= '0;    n2     <= '0;
            gamma1  <= '0;    gamma2 <= '0;    beta1  <= '0;    beta2 <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else if (!stall) begin
            v0      <= rd_en;
            last0   <= last_rd;
            mean0   <= act.mean;
            inv0    <= act.inv_sqrt;
            v1      <= v0;
            last1   <= last0;
            d1      <= d_w;
            inv1    <= inv0;
            gamma1  <= i_gamma;
            beta1   <= i_beta;
            v2      <= v1;
            last2   <= last1;
            n2      <= n_w;
            gamma2  <= gamma1;
            beta2   <= beta1;
            o_valid <= v2;
            o_last  <= last2 & v2;
            o_data  <= y_w;
        end
    end

    assign o_busy = ~fifo_empty | (state == S_RUN) | v0 | v1 | v2 | o_valid;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
